// File: rtl/mem_pkg.sv
// Shared SRAM geometry and frame-reader FSM encoding for the blocked-SRAM clients.
package mem_pkg;

  localparam int ADDR_W          = 8;
  localparam int BLOCK_BITS      = 64;
  localparam int NUM_BLOCKS      = 256;
  localparam int LEN_W           = 11;
  localparam int BYTES_PER_BLOCK = BLOCK_BITS / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/block_fifo2.sv
// Two-entry block buffer between SRAM read data and the byte serialiser.
module block_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // A write into a full buffer is accepted only when the head pops in the same cycle.
  always_comb begin
    do_rd = rd_en && (count != 2'd0);
    do_wr = wr_en && ((count != 2'd2) || do_rd);
  end

  assign rd_data = slot[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) slot[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) begin
        slot[wr_ptr] <= wr_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_rd) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_wr} - {1'b0, do_rd};
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Egress frame reader: block reads from the SRAM, serialised to a byte stream.
// Define FRAME_READER_STATS_EN to add the frames_sent / bytes_sent counters.
module frame_reader #(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS,
  parameter int NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
  parameter int LEN_W      = mem_pkg::LEN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic [BLOCK_BITS-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  done,
  output logic                  busy
`ifdef FRAME_READER_STATS_EN
 ,output logic [15:0]           frames_sent
 ,output logic [31:0]           bytes_sent
`endif
);

  localparam int BPB   = BLOCK_BITS / 8;
  localparam int IDX_W = (BPB > 1) ? $clog2(BPB) : 1;

  mem_pkg::state_t        state;
  logic [ADDR_W-1:0]      next_addr;
  logic [LEN_W-1:0]       blocks_rem;
  logic [LEN_W-1:0]       bytes_left;
  logic [LEN_W-1:0]       cmd_blocks;
  logic [LEN_W:0]         len_round;
  logic [IDX_W-1:0]       byte_idx;
  logic                   rd_pend;
  logic [2:0]             credit_use;
  logic                   issue;
  logic                   fire;
  logic                   pop;
  logic                   fifo_wr;
  logic [1:0]             fifo_count;
  logic [BLOCK_BITS-1:0]  head;

  block_fifo2 #(.W(BLOCK_BITS)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (mem_rdata),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  // rvalid is only trusted for the cycle after an issued read.
  assign fifo_wr = mem_rvalid && rd_pend;

  always_comb begin
    len_round  = {1'b0, cmd_len} + (LEN_W+1)'(BPB - 1);
    cmd_blocks = LEN_W'(len_round / (LEN_W+1)'(BPB));
  end

  // Credits cover buffered blocks, the read on the bus now and the one whose data lands now.
  always_comb begin
    credit_use = 3'(fifo_count) + 3'(mem_re) + 3'(rd_pend);
    issue      = (state == mem_pkg::ST_RUN) && (blocks_rem != '0) && (credit_use < 3'd2);
  end

  assign cmd_ready = (state == mem_pkg::ST_IDLE);
  assign busy      = (state == mem_pkg::ST_RUN);
  assign done      = (state == mem_pkg::ST_FIN);
  assign out_valid = (state == mem_pkg::ST_RUN) && (fifo_count != 2'd0);
  assign out_last  = out_valid && (bytes_left == LEN_W'(1));
  assign out_data  = out_valid ? head[8*int'(byte_idx) +: 8] : 8'h00;
  assign fire      = out_valid && out_ready;
  assign pop       = fire && ((byte_idx == IDX_W'(BPB - 1)) || out_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= mem_pkg::ST_IDLE;
      mem_re     <= 1'b0;
      mem_raddr  <= '0;
      next_addr  <= '0;
      blocks_rem <= '0;
      bytes_left <= '0;
      byte_idx   <= '0;
      rd_pend    <= 1'b0;
    end else begin
      rd_pend <= mem_re;
      mem_re  <= 1'b0;
      case (state)
        mem_pkg::ST_IDLE: begin
          if (cmd_valid) begin
            next_addr  <= cmd_addr;
            bytes_left <= cmd_len;
            blocks_rem <= cmd_blocks;
            byte_idx   <= '0;
            state      <= (cmd_len == '0) ? mem_pkg::ST_FIN : mem_pkg::ST_RUN;
          end
        end
        mem_pkg::ST_RUN: begin
          if (issue) begin
            mem_re     <= 1'b1;
            mem_raddr  <= next_addr;
            next_addr  <= (next_addr == ADDR_W'(NUM_BLOCKS - 1)) ? '0 : next_addr + 1'b1;
            blocks_rem <= blocks_rem - 1'b1;
          end
          if (fire) begin
            bytes_left <= bytes_left - 1'b1;
            byte_idx   <= pop ? '0 : byte_idx + 1'b1;
            if (out_last) state <= mem_pkg::ST_FIN;
          end
        end
        mem_pkg::ST_FIN: state <= mem_pkg::ST_IDLE;
        default:         state <= mem_pkg::ST_IDLE;
      endcase
    end
  end

`ifdef FRAME_READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_sent <= '0;
      bytes_sent  <= '0;
    end else begin
      if (done) frames_sent <= frames_sent + 1'b1;
      if (fire) bytes_sent  <= bytes_sent + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader with a behavioural 1-cycle-latency SRAM.
module tb_frame_reader;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic        mem_re;
  logic [7:0]  mem_raddr;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        done;
  logic        busy;
`ifdef FRAME_READER_STATS_EN
  logic [15:0] frames_sent;
  logic [31:0] bytes_sent;
`endif

  frame_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .mem_re     (mem_re),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .done       (done),
    .busy       (busy)
`ifdef FRAME_READER_STATS_EN
   ,.frames_sent(frames_sent)
   ,.bytes_sent (bytes_sent)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model; stray injects rvalid pulses with no read outstanding.
  logic [63:0] ram [256];
  logic        rvalid_q;
  logic        stray;
  always @(posedge clk) begin
    rvalid_q  <= mem_re;
    mem_rdata <= stray ? 64'hBADC0FFEE0DDF00D : ram[mem_raddr];
  end
  assign mem_rvalid = rvalid_q | stray;

  bit rand_ready = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  logic [9:0] exp_q [$];   // {pops_block, last, data}
  logic [7:0] addr_q [$];
  int         occ = 0;
  bit         stalled = 0;
  logic [7:0] hold_data;
  logic       hold_last;

  always @(negedge clk) begin
    logic [63:0] ea;
    logic [15:0] eb;
    logic [9:0]  e;
    if (rst_n) begin
      if (mem_re) begin
        ea = (addr_q.size() != 0) ? {56'h0, addr_q.pop_front()} : 64'hDEAD;
        check("rd_addr", {56'h0, mem_raddr}, ea);
        occ++;
        check("occupancy_le2", (occ <= 2), 1);
      end
      if (stalled)
        check("stall_hold", {out_valid, out_last, out_data}, {1'b1, hold_last, hold_data});
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          eb = {7'h0, e[8:0]};
          if (e[9]) occ--;
        end else begin
          eb = 16'hBAD0;
        end
        check("byte", {7'h0, out_last, out_data}, eb);
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  task automatic push_frame(input logic [7:0] a, input logic [10:0] len);
    logic [63:0] w;
    logic [7:0]  blk;
    int          nblk;
    nblk = (int'(len) + 7) / 8;
    for (int b = 0; b < nblk; b++) begin
      blk = a + 8'(b);
      addr_q.push_back(blk);
    end
    for (int i = 0; i < int'(len); i++) begin
      blk = a + 8'(i / 8);
      w   = ram[blk];
      exp_q.push_back({((i % 8) == 7) || (i == int'(len) - 1), i == int'(len) - 1, w[8*(i%8) +: 8]});
    end
  endtask

  task automatic issue_cmd(input logic [7:0] a, input logic [10:0] len);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = len;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [10:0] len, input bit stream);
    int k_re, k_first, k_done;
    push_frame(a, len);
    issue_cmd(a, len);
    k_re = -1; k_first = -1; k_done = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (mem_re && k_re < 0) k_re = k;
      if (out_valid && k_first < 0) k_first = k;
      if (done) begin
        k_done = k;
        break;
      end
    end
    check("done_seen", (k_done >= 0), 1);
    check("busy_at_done", busy, 0);
    check("bytes_drained", exp_q.size(), 0);
    check("reads_drained", addr_q.size(), 0);
    if (len == 0) begin
      check("len0_done_lat", (k_done <= 1), 1);
      check("len0_no_read", k_re, -1);
      check("len0_no_byte", k_first, -1);
    end else begin
      check("first_re_lat", k_re, 1);
      check("first_byte_lat", k_first, 3);
      if (stream) check("no_bubble_done", k_done, 3 + int'(len));
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {$urandom, $urandom};
    stray     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    rst_n     = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_raddr", mem_raddr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Spurious rvalid while idle must not leave a block behind.
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_ignored", out_valid, 0);

    run_frame(8'h10, 11'd16, 1'b1);
    run_frame(8'hFF, 11'd20, 1'b1);

    rand_ready = 1;
    run_frame(8'h40, 11'd64, 1'b0);
    run_frame(8'h80, 11'd37, 1'b0);
    rand_ready = 0;

    run_frame(8'h20, 11'd0, 1'b0);

    // Reset in the middle of a frame.
    push_frame(8'h30, 11'd64);
    issue_cmd(8'h30, 11'd64);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_mem_re", mem_re, 0);
    check("mid_mem_raddr", mem_raddr, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 0);
    check("mid_out_last", out_last, 0);
    check("mid_done", done, 0);
    check("mid_busy", busy, 0);
    exp_q.delete();
    addr_q.delete();
    occ     = 0;
    stalled = 0;
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", done, 0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("no_done_after_reset", done, 0);

    run_frame(8'h00, 11'd5, 1'b1);
    run_frame(8'hFE, 11'd9, 1'b1);
`ifdef FRAME_READER_STATS_EN
    check("frames_sent", frames_sent, 2);
    check("bytes_sent", bytes_sent, 14);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
